alu32_checker: RTL
==================

Name: alu32_checker

Overview:
- Self-checking responder for the 32-bit ALU (R, OF, Z outputs; 3-bit op select).
- Accepts one transaction per handshake: operands, op, and the ALU's observed outputs.
- Recomputes the golden result; shifts are computed iteratively, one bit per cycle.
- Reports pass/fail per transaction and keeps running check/error counts plus a capture of the first failure.
- Sits beside the ALU in sim and on-chip self-test harnesses as the consuming end of the stimulus stream.

Parameters:
- WIDTH, 32, operand/result width; shift amount uses the low $clog2(WIDTH) bits of B.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  transaction offered
- in_ready  out  1  checker can accept
- in_a, in_b  in  WIDTH  operands
- in_sel  in  3  op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB, 101 SRA, 110 SLL, 111 NOR
- in_r  in  WIDTH  observed result
- in_of, in_z  in  1  observed overflow / zero
- clr_counts  in  1  sync clear of counters and first-fail capture
- res_valid  out  1  one-cycle report pulse
- res_pass  out  1  observed == expected (valid with res_valid)
- exp_r  out  WIDTH  expected result (held until next report)
- exp_of, exp_z  out  1  expected flags (held until next report)
- chk_count, err_count  out  CNT_W  saturating counters
- ferr_valid  out  1  sticky: a failure has been captured
- ferr_sel  out  3  op of first failure
- ferr_a, ferr_b  out  WIDTH  operands of first failure

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE; every output 0 except in_ready=1. An in-flight transaction is dropped and not counted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch all inputs, go to EVAL.
  - EVAL: for SRA/SLL with amount n=B[4:0] != 0, load acc=A, cnt=n, go to SHIFT. Otherwise compute expected, go to REPORT. A shift with n=0 gives expected R=A.
  - SHIFT: each cycle shift acc by one bit (SRA replicates the MSB, SLL fills 0) and decrement cnt. When cnt==1, go to REPORT next cycle.
  - REPORT: compare, pulse res_valid, update counters and capture, go to IDLE.
- in_ready=0 in EVAL, SHIFT and REPORT. in_valid is ignored while not ready; the source must hold data until accepted.
- Latency: accept at edge T. res_valid is high in the cycle after edge T+2 for non-shift ops and n=0. For a shift by n>0, res_valid comes n cycles later. Next accept is possible the cycle after REPORT.
- Golden model:
  - ADD/SUB are WIDTH-bit wrap-around. SUB = A + ~B + 1.
  - exp_of is signed overflow for ADD/SUB only, 0 for all other ops.
  - exp_z = (exp_r == 0).
  - NOR = ~(A|B).
- Pass requires all three of R, OF and Z to match.
- Counters:
  - chk_count increments on every report; err_count increments on every fail. Both saturate at all-ones, no wrap.
  - On the first fail while ferr_valid=0, capture sel/a/b and set ferr_valid. Later fails do not overwrite.
- clr_counts:
  - Zeroes the counters and ferr_*, in any state.
  - If asserted in the REPORT cycle, the clear wins: that report still pulses res_valid/res_pass but is not counted or captured.
  - It does not abort the current transaction.

Decomposition:
- Shared package alu32_pkg holds:
  - op-code localparams (OP_AND … OP_NOR);
  - state encoding;
  - a function for the combinational golden result and overflow of non-shift ops.
- One sub-module, alu32_iter_shifter: loadable accumulator plus down-counter with a done flag. It is reused for both SRA and SLL via a direction input.

Test Plan:
1. ADD A=0x40000000 B=0x40000000, in_r=0x80000000 of=1 z=0 -> res_pass=1, exp_of=1, res_valid 2 cycles after accept, chk=1 err=0.
2. SUB A=0x00000020 B=0x00000002, in_r=0x0000001F of=0 z=0 -> res_pass=0, exp_r=0x0000001E, err=1, ferr_valid=1, ferr_sel=100, ferr_a=0x20. A second failing transaction leaves ferr_* unchanged.
3. Shifts:
   - SRA A=0xD724A00A B=3, in_r=0xFAE49401 -> pass, res_valid 5 cycles after accept, in_ready low throughout.
   - SLL A=0x5700A02E B=1 -> exp_r=0xAE01405C.
   - SLL B=0x20 (n=0) -> exp_r=A, latency 2.
4. NOR A=0xFFFFFFFF B=0, in_r=0 z=1 -> pass, exp_z=1, exp_of=0. AND with observed of=1 -> fail (of mismatch).
5. in_valid held high during SHIFT -> no second accept until IDLE. rst_n=0 mid-SHIFT -> no res_valid, counters 0, in_ready=1 next cycle.
6. CNT_W=2: drive 5 failing transactions -> chk=err=3 (saturated). clr_counts in REPORT cycle -> res_valid pulses, counters read 0.

Source files
------------

// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - op codes, checker state encoding and golden model for the 32-bit ALU checker
package alu32_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    localparam int GOLD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_SHIFT,
        ST_REPORT
    } chk_state_t;

    typedef struct packed {
        logic [GOLD_W-1:0] r;
        logic              of;
    } golden_t;

    // Non-shift ops only; SUB is A + ~B + 1 so both arithmetic ops share one overflow rule.
    function automatic golden_t alu_golden(input logic [GOLD_W-1:0] a,
                                           input logic [GOLD_W-1:0] b,
                                           input logic [2:0]        sel,
                                           input logic [4:0]        msb);
        golden_t           g;
        logic [GOLD_W-1:0] bb;
        g.r  = '0;
        g.of = 1'b0;
        bb   = (sel == OP_SUB) ? ~b : b;
        case (sel)
            OP_AND: g.r = a & b;
            OP_OR:  g.r = a | b;
            OP_XOR: g.r = a ^ b;
            OP_NOR: g.r = ~(a | b);
            OP_ADD, OP_SUB: begin
                g.r  = a + bb + GOLD_W'(sel == OP_SUB);
                g.of = (a[msb] == bb[msb]) && (g.r[msb] != a[msb]);
            end
            default: g.r = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/alu32_iter_shifter.sv
// rtl/alu32_iter_shifter.sv - one-bit-per-cycle shifter: loadable accumulator plus down-counter
module alu32_iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             dir_left,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SH_W-1:0]  load_amt,
    output logic [WIDTH-1:0] acc,
    output logic             done
);

    logic [SH_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= load_data;
            cnt <= load_amt;
        end else if (step) begin
            acc <= dir_left ? {acc[WIDTH-2:0], 1'b0} : {acc[WIDTH-1], acc[WIDTH-1:1]};
            cnt <= cnt - SH_W'(1);
        end
    end

    // High during the final step, so the owner can leave its shift state on that edge.
    assign done = (cnt == SH_W'(1));

endmodule

// File: rtl/alu32_checker.sv
// rtl/alu32_checker.sv - self-checking responder for the 32-bit ALU with counters and first-fail capture
module alu32_checker
    import alu32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_r,
    input  logic             in_of,
    input  logic             in_z,
    input  logic             clr_counts,
    output logic             res_valid,
    output logic             res_pass,
    output logic [WIDTH-1:0] exp_r,
    output logic             exp_of,
    output logic             exp_z,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             ferr_valid,
    output logic [2:0]       ferr_sel,
    output logic [WIDTH-1:0] ferr_a,
    output logic [WIDTH-1:0] ferr_b
);

    localparam int         SH_W = $clog2(WIDTH);
    localparam logic [4:0] MSB  = 5'(WIDTH - 1);

    chk_state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic [2:0]       sel_q;
    logic             of_q, z_q;

    logic [SH_W-1:0]  sh_amt;
    logic             is_shift, sh_run, sh_done;
    logic [WIDTH-1:0] sh_acc;

    golden_t          gold;
    logic [WIDTH-1:0] calc_r;
    logic             calc_of, calc_z, calc_pass;

    assign sh_amt   = b_q[SH_W-1:0];
    assign is_shift = (sel_q == OP_SRA) || (sel_q == OP_SLL);
    assign sh_run   = is_shift && (sh_amt != '0);

    alu32_iter_shifter #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      ((state == ST_EVAL) && sh_run),
        .step      (state == ST_SHIFT),
        .dir_left  (sel_q == OP_SLL),
        .load_data (a_q),
        .load_amt  (sh_amt),
        .acc       (sh_acc),
        .done      (sh_done)
    );

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ST_EVAL;
            end
            ST_EVAL:   state_n = sh_run ? ST_SHIFT : ST_REPORT;
            ST_SHIFT:  if (sh_done) state_n = ST_REPORT;
            ST_REPORT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        gold = alu_golden(GOLD_W'(a_q), GOLD_W'(b_q), sel_q, MSB);
        if (is_shift) begin
            calc_r  = sh_run ? sh_acc : a_q;
            calc_of = 1'b0;
        end else begin
            calc_r  = WIDTH'(gold.r);
            calc_of = gold.of;
        end
        calc_z    = (calc_r == '0);
        calc_pass = (r_q == calc_r) && (of_q == calc_of) && (z_q == calc_z);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            sel_q      <= '0;
            of_q       <= 1'b0;
            z_q        <= 1'b0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            exp_r      <= '0;
            exp_of     <= 1'b0;
            exp_z      <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
            ferr_valid <= 1'b0;
            ferr_sel   <= '0;
            ferr_a     <= '0;
            ferr_b     <= '0;
        end else begin
            state     <= state_n;
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            if ((state == ST_IDLE) && in_valid) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sel_q <= in_sel;
                r_q   <= in_r;
                of_q  <= in_of;
                z_q   <= in_z;
            end
            if (state == ST_REPORT) begin
                res_valid <= 1'b1;
                res_pass  <= calc_pass;
                exp_r     <= calc_r;
                exp_of    <= calc_of;
                exp_z     <= calc_z;
                if (chk_count != '1) chk_count <= chk_count + CNT_W'(1);
                if (!calc_pass) begin
                    if (err_count != '1) err_count <= err_count + CNT_W'(1);
                    if (!ferr_valid) begin
                        ferr_valid <= 1'b1;
                        ferr_sel   <= sel_q;
                        ferr_a     <= a_q;
                        ferr_b     <= b_q;
                    end
                end
            end
            // Placed last so a clear in the report cycle overrides that report's bookkeeping.
            if (clr_counts) begin
                chk_count  <= '0;
                err_count  <= '0;
                ferr_valid <= 1'b0;
                ferr_sel   <= '0;
                ferr_a     <= '0;
                ferr_b     <= '0;
            end
        end
    end

endmodule
